// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared constants for the counter timebase.
// Direction encodings and default WIDTH / DIV_BITS values.
package prog_counter_pkg;

  localparam int PC_WIDTH    = 4;
  localparam int PC_DIV_BITS = 24;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider, one-cycle tick every 2^DIV_BITS.
// Ports: mainClock, reset (async high), enable, tick (registered).
module tick_prescaler
  import prog_counter_pkg::*;
#(
  parameter int DIV_BITS = PC_DIV_BITS
) (
  input  logic mainClock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [DIV_BITS-1:0] p;

  always_ff @(posedge mainClock or posedge reset) begin
    if (reset) begin
      p    <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      p    <= p + 1'b1;
      tick <= (p == '1);
    end else begin
      p    <= '0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: up/down counter stepped by tick_prescaler, with load.
// Ports: mainClock, reset, enable, dir, load, loadValue, [saturate],
// count, tick, terminal. PROG_COUNTER_SAT_EN adds saturate clamping.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int              WIDTH       = PC_WIDTH,
  parameter int              DIV_BITS    = PC_DIV_BITS,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             mainClock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
`ifdef PROG_COUNTER_SAT_EN
  input  logic             saturate,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             terminal
);

  logic             atLimit;
  logic             clamp;
  logic [WIDTH-1:0] stepped;

  tick_prescaler #(
    .DIV_BITS (DIV_BITS)
  ) uPre (
    .mainClock (mainClock),
    .reset     (reset),
    .enable    (enable),
    .tick      (tick)
  );

  // atLimit: the step would wrap (max going up, 0 going down)
  always_comb begin
    atLimit = 1'b0;
    stepped = count;
    if (dir == DIR_UP) begin
      atLimit = (count == '1);
      stepped = count + 1'b1;
    end else begin
      atLimit = (count == '0);
      stepped = count - 1'b1;
    end
`ifdef PROG_COUNTER_SAT_EN
    clamp = saturate & atLimit;
`else
    clamp = 1'b0;
`endif
  end

  always_ff @(posedge mainClock or posedge reset) begin
    if (reset) begin
      count    <= RESET_VALUE;
      terminal <= 1'b0;
    end else if (load) begin
      count    <= loadValue;
      terminal <= 1'b0;
    end else if (tick) begin
      if (!clamp) count <= stepped;
      terminal <= atLimit;
    end else begin
      terminal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed stimulus, step scoreboard and monitor.
// WIDTH=4, DIV_BITS=2; define PROG_COUNTER_SAT_EN for clamp cases.
module tb_prog_counter;

  typedef struct packed {
    logic [3:0] cnt;
    logic       term;
  } exp_t;

  logic       mainClock = 1'b0;
  logic       reset     = 1'b0;
  logic       enable    = 1'b0;
  logic       dir       = 1'b0;
  logic       load      = 1'b0;
  logic [3:0] loadValue = 4'h0;
`ifdef PROG_COUNTER_SAT_EN
  logic       saturate  = 1'b0;
`endif
  logic [3:0] count;
  logic       tick;
  logic       terminal;

  exp_t q[$];
  int   nChk  = 0;
  int   nPass = 0;

  prog_counter #(
    .WIDTH    (4),
    .DIV_BITS (2)
  ) dut (
    .mainClock (mainClock),
    .reset     (reset),
    .enable    (enable),
    .dir       (dir),
    .load      (load),
    .loadValue (loadValue),
`ifdef PROG_COUNTER_SAT_EN
    .saturate  (saturate),
`endif
    .count     (count),
    .tick      (tick),
    .terminal  (terminal)
  );

  initial forever #5 mainClock = ~mainClock;

  function automatic void check(string name,
                                int act, int req);
    nChk++;
    if (act === req) nPass++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, req);
  endfunction

  function automatic void push(int c, int t);
    exp_t e;
    e.cnt  = c[3:0];
    e.term = t[0];
    q.push_back(e);
  endfunction

  task automatic waitTick(output int k);
    k = 0;
    while (k < 40) begin
      @(negedge mainClock);
      #1;
      k++;
      if (tick) break;
    end
  endtask

  task automatic waitEmpty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge mainClock);
      #1;
      n++;
    end
    check("drain", q.size(), 0);
    q.delete();
  endtask

  // monitor: a step happened on the edge after tick was seen high
  initial begin
    logic prevTick;
    logic prevTerm;
    exp_t e;
    prevTick = 1'b0;
    prevTerm = 1'b0;
    forever begin
      @(negedge mainClock);
      if (reset) begin
        prevTick = 1'b0;
        prevTerm = 1'b0;
      end else begin
        if (prevTerm) check("termWidth", int'(terminal), 0);
        if (prevTick) begin
          check("tickWidth", int'(tick), 0);
          if (q.size() == 0) begin
            nChk++;
            $display("FAIL unexpStep: got count %0d want none",
                     count);
          end else begin
            e = q.pop_front();
            check("stepCount", int'(count), int'(e.cnt));
            check("stepTerm", int'(terminal), int'(e.term));
          end
        end
        prevTick = (tick === 1'b1);
        prevTerm = (terminal === 1'b1);
      end
    end
  end

  initial begin
    int k;
    #1 reset = 1'b1;
    @(negedge mainClock);
    @(negedge mainClock);
    check("rstCount", int'(count), 15);
    check("rstTick", int'(tick), 0);
    check("rstTerm", int'(terminal), 0);
    #1 reset = 1'b0;

    for (int v = 14; v >= 0; v--) push(v, 0);
    push(15, 1);
    push(14, 0);
    enable = 1'b1;
    waitTick(k);
    check("firstStep", k, 4);
    waitEmpty();

    dir = 1'b1;
    push(15, 0);
    push(0, 1);
    push(1, 0);
    waitEmpty();

    dir = 1'b0;
    push(7, 0);
    push(6, 0);
    waitTick(k);
    loadValue = 4'h7;
    load = 1'b1;
    @(negedge mainClock);
    #1 load = 1'b0;
    waitEmpty();

    loadValue = 4'h3;
    load = 1'b1;
    @(negedge mainClock);
    #1 load = 1'b0;
    check("loadCount", int'(count), 3);
    check("loadTerm", int'(terminal), 0);
    push(2, 0);
    waitEmpty();

    enable = 1'b0;
    repeat (3) begin
      @(negedge mainClock);
      #1;
      check("offTick", int'(tick), 0);
      check("offCount", int'(count), 2);
    end
    enable = 1'b1;
    push(1, 0);
    waitTick(k);
    check("reenStep", k, 4);
    waitEmpty();

`ifdef PROG_COUNTER_SAT_EN
    loadValue = 4'hF;
    load = 1'b1;
    dir = 1'b1;
    saturate = 1'b1;
    @(negedge mainClock);
    #1 load = 1'b0;
    check("satLoad", int'(count), 15);
    push(15, 1);
    waitEmpty();
    saturate = 1'b0;
    push(0, 1);
    waitEmpty();
    dir = 1'b0;
    saturate = 1'b1;
    push(0, 1);
    waitEmpty();
`endif

    waitTick(k);
    #1 reset = 1'b1;
    #1;
    check("asyncCount", int'(count), 15);
    check("asyncTick", int'(tick), 0);
    check("asyncTerm", int'(terminal), 0);
    @(negedge mainClock);
    @(negedge mainClock);
    push(14, 0);
    #1 reset = 1'b0;
    waitTick(k);
    check("postRstStep", k, 4);
    waitEmpty();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised up/down counter with an integrated prescaler, replacing the fixed 4-bit down-counter and its derived slow clock. All logic runs on `mainClock`. The prescaler produces a single-cycle clock-enable strobe instead of a generated clock. Supports direction control, synchronous load, a terminal-count pulse and optional saturation; it feeds the board LED/display path and serves as the generic timebase for later labs.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits.
- `DIV_BITS`, 24: prescaler width; one step every 2^DIV_BITS enabled cycles; legal range 1..32.
- `RESET_VALUE`, {WIDTH{1'b1}}: value of `count` after reset.

Ports:
- `mainClock`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: runs the prescaler; when low, the prescaler clears and `count` holds.
- `dir`, in, 1: 1 = count up, 0 = count down; sampled on the step edge.
- `load`, in, 1: synchronous load of `loadValue`.
- `loadValue`, in, WIDTH: value loaded into `count`.
- `saturate`, in, 1: present only with `PROG_COUNTER_SAT_EN`; 1 = clamp at limits, 0 = wrap.
- `count`, out, WIDTH: registered counter value.
- `tick`, out, 1: registered one-cycle prescaler strobe.
- `terminal`, out, 1: registered one-cycle pulse on wrap or at a saturated limit.

## Operation
- Reset (async assert; deassert is synchronised externally) sets:
  - `count` = RESET_VALUE.
  - Prescaler = 0.
  - `tick` = 0.
  - `terminal` = 0.
- Prescaler `p`, DIV_BITS wide:
  - `enable`=1: `p` <= `p`+1, wrapping.
  - `enable`=0: `p` <= 0 and `tick` <= 0.
- `tick` <= `enable` & (`p` == 2^DIV_BITS-1).
- A step occurs on an edge where `tick`=1 and `load`=0:
  - `dir`=1: `count` <= `count`+1, modulo 2^WIDTH.
  - `dir`=0: `count` <= `count`-1, modulo 2^WIDTH.
- `terminal` <= 1 when a step moves max→0 (up) or 0→max (down); 0 otherwise.
- Saturation (`saturate`=1, macro on): a step at max going up, or at 0 going down, leaves `count` unchanged and pulses `terminal`.
- `load`=1:
  - `count` <= `loadValue` regardless of `enable` or `tick`.
  - `terminal` <= 0.
  - The prescaler is unaffected.
- `dir` changes between steps take effect on the next step. No state machine beyond the prescaler and counter.

## Timing
- The first step after `enable` rises from a cleared prescaler lands on edge 2^DIV_BITS+1. Steps then repeat every 2^DIV_BITS cycles.
- `tick` and `terminal` are each high for exactly one cycle. `terminal` is high in the cycle after the step edge, aligned with the new `count`.
- `load` latency is 1 cycle. `load` has priority over a coincident `tick`, and that step is lost rather than deferred.
- If `enable` falls while `tick`=1, the step on that edge still occurs.
- `reset` mid-operation: outputs take reset values immediately. The first step after release follows the rule above.

## Configuration
- `PROG_COUNTER_SAT_EN`:
  - Defined: the `saturate` port exists and clamp behaviour applies when it is 1.
  - Undefined: the port is absent and the counter always wraps.
- Wrap behaviour is identical in both builds.

## Structure
- Package `prog_counter_pkg`:
  - Direction constants `DIR_UP`=1 and `DIR_DOWN`=0.
  - Default values of `WIDTH` and `DIV_BITS`.
- Sub-module `tick_prescaler`:
  - Parameter `DIV_BITS`.
  - Ports: `mainClock`, `reset`, `enable`, `tick`.
  - Reusable by other timebase blocks.
- The counter/terminal logic stays in `prog_counter`.

## Test plan
Defaults: WIDTH=4, DIV_BITS=2 (`tick` every 4 cycles) unless stated.
- Reset, `dir`=0, `enable`=1 → `count` = F, then E, D, … one step per 4 cycles. First step on edge 5. `tick` is high for exactly 1 cycle each time.
- `dir`=0 from `count`=1 → 0, then F with `terminal`=1 for one cycle. `dir`=1 from E → F, then 0 with `terminal` pulsed.
- `load`=1, `loadValue`=7 on the same edge as `tick`=1 → `count`=7, no step, `terminal`=0. The next step gives 6 (`dir`=0).
- `enable` dropped mid-period for 3 cycles, then raised → `count` holds and `tick` stays 0. The next step comes 5 cycles after re-enable.
- Macro on, `saturate`=1, `dir`=1, `count`=F, `tick` → `count` stays F and `terminal`=1. With `saturate`=0 → `count`=0.
- `reset` asserted asynchronously mid-period → `count`=F and `tick`/`terminal`=0 with no clock edge. After release, the first step lands on edge 5.
